// File: rtl/flat_io_pkg.sv
// Shared definitions for the flattened-IO frame serializer and its
// host-side counterparts: FSM state encoding, frame header byte and the
// byte-wise XOR checksum.
package flat_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_e;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    // Widest word xor_bytes can fold; callers zero-extend into this width.
    localparam int XOR_MAX_BYTES = 32;
    localparam int XOR_MAX_BITS  = XOR_MAX_BYTES * 8;

    // XOR of the low nb byte slices of word. Bytes above nb are ignored,
    // so one function serves every word width up to XOR_MAX_BYTES.
    function automatic logic [7:0] xor_bytes(input logic [XOR_MAX_BITS-1:0] word,
                                             input int                      nb);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < XOR_MAX_BYTES; i++) begin
            if (i < nb) begin
                acc = acc ^ word[i*8 +: 8];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/flat_result_serializer.sv
// Streams one captured WIDTH-bit word to the host as a byte frame:
// header, data bytes MSB-first, then an XOR checksum byte marked tx_last.
module flat_result_serializer
    import flat_io_pkg::*;
#(
    parameter int         WIDTH  = 40,
    parameter logic [7:0] HEADER = FRAME_HEADER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_valid,
    output logic             cap_ready,
    input  logic [WIDTH-1:0] cap_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_last,
    output logic             busy
);

    localparam int NB = WIDTH / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);

    if ((WIDTH % 8) != 0 || WIDTH < 8 || WIDTH > XOR_MAX_BITS) begin : g_bad_width
        $error("flat_result_serializer: WIDTH must be a multiple of 8 in [8, %0d]", XOR_MAX_BITS);
    end

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic [7:0]          csum_q,  csum_d;
    logic [IW-1:0]       idx_q,   idx_d;
    logic [XOR_MAX_BITS-1:0] cap_ext;

    // Zero-extend the capture word to the checksum helper's fixed width.
    always_comb begin
        cap_ext            = '0;
        cap_ext[WIDTH-1:0] = cap_data;
    end

    // Next-state logic for the frame FSM, shift register, index and checksum.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        shreg_d = shreg_q;
        csum_d  = csum_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (cap_valid) begin
                    shreg_d = cap_data;
                    csum_d  = xor_bytes(cap_ext, NB);
                    state_d = HDR;
                end
            end
            HDR: begin
                if (tx_ready) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tx_ready) begin
                    // Shift the next byte into the top slot; idx only decides
                    // when the last data byte has gone.
                    shreg_d = shreg_q << 8;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset takes priority over any handshake in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of its inputs.
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            csum_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            csum_q  <= csum_d;
            idx_q   <= idx_d;
        end
    end

    // Output decode from registered state only; tx_ready never reaches tx_data.
    always_comb begin
        tx_data = '0;
        unique case (state_q)
            HDR:     tx_data = HEADER;
            DATA:    tx_data = shreg_q[WIDTH-1 -: 8];
            CSUM:    tx_data = csum_q;
            default: tx_data = '0;
        endcase
    end

    assign tx_valid  = (state_q != IDLE);
    assign tx_last   = (state_q == CSUM);
    assign busy      = (state_q != IDLE);
    assign cap_ready = !rst && (state_q == IDLE);

endmodule
